mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
// - MEM/WB pipeline stage; sole producer of mem_wb_bus_t for the register file write port.
// - Takes ALU results and load requests from EX/MEM and waits for the data-memory response.
// - Sign/zero-extends load data and drives exactly one write-back beat per retired instruction.
// - Reports load faults on excpt_out/excpt_inst_out, which the register file latches.
// PARAMETERS
// - MEM_TIMEOUT   16   cycles in WAIT_LOAD before a load is faulted (>=2)
// - CNT_W         5    timeout counter width; must hold MEM_TIMEOUT
// PORTS
// - clock           in   1              single clock, rising edge
// - reset           in   1              asynchronous, active-high
// - ex_mem_valid    in   1              ex_mem_bus_in holds an instruction
// - ex_mem_bus_in   in   ex_mem_bus_t   {opcode, rd, funct3, alu_result[31:0], inst[31:0]}
// - ex_mem_ready    out  1              stage accepts ex_mem_bus_in this cycle
// - dmem_rsp_valid  in   1              load data valid (one-cycle pulse)
// - dmem_rsp_data   in   32             aligned 32-bit word from data memory
// - flush           in   1              discard pending/incoming instruction
// - mem_wb_bus_out  out  mem_wb_bus_t   {opcode, rd, wb_value[31:0]} to register file
// - excpt_out       out  3              exception code, 0 = none
// - excpt_inst_out  out  32             faulting instruction word
// BEHAVIOUR
// - Reset (async): state=IDLE; mem_wb_bus_out.opcode=NOP, rd=0, wb_value=0; excpt_out=0;
//   excpt_inst_out=0; timeout counter=0. ex_mem_ready=1 in IDLE.
// - Handshake: transfer when ex_mem_valid && ex_mem_ready. ex_mem_ready = (state==IDLE).
// - All outputs registered. Every cycle with no retire drives opcode=NOP (no write).
// - IDLE, ALUopR/ALUopI accepted: next cycle {opcode, rd, wb_value=alu_result}; one beat.
// - IDLE, other non-load opcodes (store/branch): accepted, NOP beat.
// - IDLE, LW accepted: alignment check on alu_result[1:0] by funct3:
//   - LB/LBU (000/100): any offset legal. LH/LHU (001/101): bit0 must be 0. LW (010): [1:0]==0.
//   - Misaligned: next cycle excpt_out=EXC_LD_MISALIGN, excpt_inst_out=inst, opcode=NOP; stay IDLE.
//   - Aligned: capture rd/funct3/offset/inst, go WAIT_LOAD, clear counter.
// - WAIT_LOAD: counter increments each cycle; ex_mem_ready=0.
//   - dmem_rsp_valid: select byte/half by offset, sign-extend (LB/LH) or zero-extend (LBU/LHU),
//     next cycle {opcode=LW, rd, wb_value}; go IDLE. Load latency = rsp cycle + 1.
//   - counter==MEM_TIMEOUT-1 without rsp: next cycle excpt_out=EXC_LD_TIMEOUT, opcode=NOP; go IDLE.
//   - rsp and timeout in same cycle: rsp wins, no exception.
// - excpt_out held nonzero for exactly one cycle, then 0.
// - dmem_rsp_valid in IDLE: ignored (late response after timeout/flush dropped).
// - flush: highest priority. Incoming instruction not accepted as retire, WAIT_LOAD aborts to IDLE,
//   next-cycle output NOP with excpt_out=0.
// - rd==0: beat still driven with opcode; register file suppresses write.
// - Reset mid-WAIT_LOAD: immediate return to IDLE, no beat, no exception.
// STRUCTURE
// - Shared pipeline package: opcodes (LW, ALUopR, ALUopI, NOP), ex_mem_bus_t, mem_wb_bus_t,
//   funct3 load encodings, EXC_NONE=0, EXC_LD_MISALIGN=1, EXC_LD_TIMEOUT=2.
// - Sub-module load_extend: combinational funct3/offset/word -> 32-bit extended value.
// - FSM {IDLE, WAIT_LOAD} plus timeout counter live in mem_wb_stage.
// TESTING
// - ALUopI rd=5 alu_result=0x1234 -> 1 cycle later opcode=ALUopI rd=5 wb=0x1234, then NOP.
// - LW rd=3 addr 0x100, rsp 0xDEADBEEF after 4 cycles -> ready=0 while waiting, wb=0xDEADBEEF.
// - LB addr 0x103, rsp 0x80FF0000 -> wb=0xFFFFFF80; LBU same -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
// - LW addr 0x102 -> excpt_out=1 for 1 cycle, excpt_inst_out=inst, no write, ready stays 1.
// - LW, no rsp for 16 cycles -> excpt_out=2, back to IDLE; rsp arriving later ignored.
// - LW then flush in WAIT_LOAD -> NOP, excpt_out=0, ready=1 next cycle; async reset mid-load same.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline opcodes, EX/MEM and MEM/WB bus types, load funct3 and exception codes
package mem_wb_stage_pkg;
  typedef enum logic [6:0] {
    NOP    = 7'b0000000,
    LW     = 7'b0000011,
    ALUopI = 7'b0010011,
    STORE  = 7'b0100011,
    ALUopR = 7'b0110011,
    BRANCH = 7'b1100011
  } opcode_t;
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] inst;
  } ex_mem_bus_t;
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [31:0] wb_value;
  } mem_wb_bus_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] EXC_NONE        = 3'd0;
  localparam logic [2:0] EXC_LD_MISALIGN = 3'd1;
  localparam logic [2:0] EXC_LD_TIMEOUT  = 3'd2;
  function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset != 2'b00);
  endfunction
endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: picks the byte/half at offset from an aligned word and sign- or zero-extends it by funct3
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    value = funct3 == F3_LB  ? {{24{b[7]}}, b} :
            funct3 == F3_LBU ? {24'b0, b} :
            funct3 == F3_LH  ? {{16{h[15]}}, h} :
            funct3 == F3_LHU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage (clock, reset, ex_mem valid/bus/ready, dmem rsp, flush -> mem_wb_bus_out, excpt_out, excpt_inst_out)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_mem_valid,
  input  ex_mem_bus_t ex_mem_bus_in,
  output logic        ex_mem_ready,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_data,
  input  logic        flush,
  output mem_wb_bus_t mem_wb_bus_out,
  output logic [2:0]  excpt_out,
  output logic [31:0] excpt_inst_out
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       p_rd;
  logic [2:0]       p_f3;
  logic [1:0]       p_off;
  logic [31:0]      p_inst;
  logic [31:0]      ext;
  assign ex_mem_ready = state == IDLE;
  load_extend u_ext (
    .funct3(p_f3),
    .offset(p_off),
    .word  (dmem_rsp_data),
    .value (ext)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      p_rd           <= '0;
      p_f3           <= '0;
      p_off          <= '0;
      p_inst         <= '0;
      mem_wb_bus_out <= '{opcode: NOP, rd: '0, wb_value: '0};
      excpt_out      <= EXC_NONE;
      excpt_inst_out <= '0;
    end else begin
      mem_wb_bus_out <= '{opcode: NOP, rd: '0, wb_value: '0};
      excpt_out      <= EXC_NONE;
      if (flush) begin
        state <= IDLE;
      end else if (state == WAIT_LOAD) begin
        if (dmem_rsp_valid) begin
          mem_wb_bus_out <= '{opcode: LW, rd: p_rd, wb_value: ext};
          state          <= IDLE;
        end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          excpt_out      <= EXC_LD_TIMEOUT;
          excpt_inst_out <= p_inst;
          state          <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (ex_mem_valid) begin
        if (ex_mem_bus_in.opcode == ALUopR || ex_mem_bus_in.opcode == ALUopI) begin
          mem_wb_bus_out <= '{opcode: ex_mem_bus_in.opcode, rd: ex_mem_bus_in.rd, wb_value: ex_mem_bus_in.alu_result};
        end else if (ex_mem_bus_in.opcode == LW) begin
          if (load_misaligned(ex_mem_bus_in.funct3, ex_mem_bus_in.alu_result[1:0])) begin
            excpt_out      <= EXC_LD_MISALIGN;
            excpt_inst_out <= ex_mem_bus_in.inst;
          end else begin
            p_rd   <= ex_mem_bus_in.rd;
            p_f3   <= ex_mem_bus_in.funct3;
            p_off  <= ex_mem_bus_in.alu_result[1:0];
            p_inst <= ex_mem_bus_in.inst;
            cnt    <= '0;
            state  <= WAIT_LOAD;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized and directed checks of mem_wb_stage against a transaction-level load/retire model
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;
  localparam int MEM_TIMEOUT = 16;
  logic        clock = 0;
  logic        reset = 1;
  logic        ex_mem_valid = 0;
  ex_mem_bus_t ex_mem_bus_in = '0;
  logic        ex_mem_ready;
  logic        dmem_rsp_valid = 0;
  logic [31:0] dmem_rsp_data = '0;
  logic        flush = 0;
  mem_wb_bus_t mem_wb_bus_out;
  logic [2:0]  excpt_out;
  logic [31:0] excpt_inst_out;
  int vectors = 0;
  int miscompares = 0;
  bit          busy;
  int          age;
  logic [4:0]  p_rd;
  logic [2:0]  p_f3;
  logic [1:0]  p_off;
  logic [31:0] p_inst;
  opcode_t     e_op;
  logic [4:0]  e_rd;
  logic [31:0] e_wb;
  logic [2:0]  e_exc;
  logic [31:0] e_einst;
  mem_wb_stage #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .ex_mem_valid(ex_mem_valid), .ex_mem_bus_in(ex_mem_bus_in),
    .ex_mem_ready(ex_mem_ready), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
    .flush(flush), .mem_wb_bus_out(mem_wb_bus_out), .excpt_out(excpt_out), .excpt_inst_out(excpt_inst_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned byte_v, half_v;
    byte_v = (w >> (8 * off)) % 256;
    half_v = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'b000:  return (byte_v >= 128) ? 32'(byte_v) - 32'd256 : 32'(byte_v);
      3'b100:  return 32'(byte_v);
      3'b001:  return (half_v >= 32768) ? 32'(half_v) - 32'd65536 : 32'(half_v);
      3'b101:  return 32'(half_v);
      default: return w;
    endcase
  endfunction
  function automatic bit model_bad_align(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001, 3'b101: return off % 2 != 0;
      3'b010:         return off != 0;
      default:        return 0;
    endcase
  endfunction
  task automatic check_outputs();
    check("opcode", 64'(mem_wb_bus_out.opcode), 64'(e_op));
    if (e_op != NOP) begin
      check("rd", 64'(mem_wb_bus_out.rd), 64'(e_rd));
      check("wb_value", 64'(mem_wb_bus_out.wb_value), 64'(e_wb));
    end
    check("excpt", 64'(excpt_out), 64'(e_exc));
    if (e_exc != EXC_NONE) check("excpt_inst", 64'(excpt_inst_out), 64'(e_einst));
  endtask
  task automatic cycle(input logic v, input ex_mem_bus_t b, input logic rv, input logic [31:0] rdata, input logic fl);
    ex_mem_valid = v;
    ex_mem_bus_in = b;
    dmem_rsp_valid = rv;
    dmem_rsp_data = rdata;
    flush = fl;
    #1;
    check("ready", 64'(ex_mem_ready), 64'(!busy));
    e_op = NOP;
    e_rd = '0;
    e_wb = '0;
    e_exc = EXC_NONE;
    if (fl) begin
      busy = 0;
    end else if (busy) begin
      age++;
      if (rv) begin
        e_op = LW;
        e_rd = p_rd;
        e_wb = model_ext(p_f3, p_off, rdata);
        busy = 0;
      end else if (age == MEM_TIMEOUT) begin
        e_exc = EXC_LD_TIMEOUT;
        e_einst = p_inst;
        busy = 0;
      end
    end else if (v) begin
      if (b.opcode == ALUopR || b.opcode == ALUopI) begin
        e_op = b.opcode;
        e_rd = b.rd;
        e_wb = b.alu_result;
      end else if (b.opcode == LW) begin
        if (model_bad_align(b.funct3, b.alu_result[1:0])) begin
          e_exc = EXC_LD_MISALIGN;
          e_einst = b.inst;
        end else begin
          busy = 1;
          age = 0;
          p_rd = b.rd;
          p_f3 = b.funct3;
          p_off = b.alu_result[1:0];
          p_inst = b.inst;
        end
      end
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 32'h0, 0);
  endtask
  task automatic async_reset();
    #2 reset = 1;
    #1;
    check("rst_opcode", 64'(mem_wb_bus_out.opcode), 64'(NOP));
    check("rst_excpt", 64'(excpt_out), 64'(EXC_NONE));
    check("rst_einst", 64'(excpt_inst_out), 64'h0);
    check("rst_ready", 64'(ex_mem_ready), 64'h1);
    busy = 0;
    e_einst = '0;
    @(posedge clock);
    #3 reset = 0;
  endtask
  function automatic ex_mem_bus_t mk(input opcode_t op, input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] a);
    return '{opcode: op, rd: rd, funct3: f3, alu_result: a, inst: {a[15:0], 4'hA, rd, f3, 7'(op)} ^ 32'h5A000000};
  endfunction
  initial begin
    opcode_t     ops [6] = '{LW, LW, ALUopR, ALUopI, STORE, BRANCH};
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    ex_mem_bus_t b;
    busy = 0;
    age = 0;
    e_einst = '0;
    #12;
    check("rst_opcode", 64'(mem_wb_bus_out.opcode), 64'(NOP));
    check("rst_rd", 64'(mem_wb_bus_out.rd), 64'h0);
    check("rst_wb", 64'(mem_wb_bus_out.wb_value), 64'h0);
    check("rst_excpt", 64'(excpt_out), 64'h0);
    check("rst_einst", 64'(excpt_inst_out), 64'h0);
    check("rst_ready", 64'(ex_mem_ready), 64'h1);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    cycle(1, mk(ALUopI, 5, 3'b000, 32'h1234), 0, 0, 0);
    check("alui_wb", 64'(mem_wb_bus_out.wb_value), 64'h1234);
    idle(1);
    cycle(1, mk(LW, 3, F3_LW, 32'h100), 0, 0, 0);
    idle(3);
    cycle(0, '0, 1, 32'hDEADBEEF, 0);
    check("lw_wb", 64'(mem_wb_bus_out.wb_value), 64'hDEADBEEF);
    cycle(1, mk(LW, 7, F3_LB, 32'h103), 0, 0, 0);
    cycle(0, '0, 1, 32'h80FF0000, 0);
    check("lb_wb", 64'(mem_wb_bus_out.wb_value), 64'hFFFFFF80);
    cycle(1, mk(LW, 7, F3_LBU, 32'h103), 0, 0, 0);
    cycle(0, '0, 1, 32'h80FF0000, 0);
    check("lbu_wb", 64'(mem_wb_bus_out.wb_value), 64'h00000080);
    cycle(1, mk(LW, 8, F3_LH, 32'h102), 0, 0, 0);
    idle(2);
    cycle(0, '0, 1, 32'h80FF0000, 0);
    check("lh_wb", 64'(mem_wb_bus_out.wb_value), 64'hFFFF80FF);
    b = mk(LW, 9, F3_LW, 32'h102);
    cycle(1, b, 0, 0, 0);
    check("mis_code", 64'(excpt_out), 64'h1);
    idle(2);
    cycle(1, mk(LW, 10, F3_LW, 32'h200), 0, 0, 0);
    idle(MEM_TIMEOUT);
    check("tmo_code", 64'(excpt_out), 64'h2);
    cycle(0, '0, 1, 32'h12345678, 0);
    idle(1);
    cycle(1, mk(LW, 11, F3_LW, 32'h300), 0, 0, 0);
    idle(2);
    cycle(0, '0, 1, 32'hCAFEF00D, 1);
    idle(2);
    cycle(1, mk(LW, 12, F3_LHU, 32'h302), 0, 0, 0);
    idle(MEM_TIMEOUT - 1);
    cycle(0, '0, 1, 32'hA5A5_8001, 0);
    cycle(1, mk(LW, 13, F3_LW, 32'h400), 0, 0, 0);
    idle(3);
    async_reset();
    idle(2);
    cycle(1, mk(ALUopR, 0, 3'b000, 32'hFFFF0000), 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      b = mk(ops[$urandom_range(0, 5)], 5'($urandom), f3s[$urandom_range(0, 4)], $urandom);
      b.inst = $urandom;
      cycle($urandom_range(0, 9) < 6, b, $urandom_range(0, 99) < 15, $urandom, $urandom_range(0, 99) < 5);
      if ($urandom_range(0, 999) == 0) async_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
